// File: rtl/regfile_reader_pkg.sv
// Shared types, sizing constants and the drain-count clamp for the regfile reader.
package regfile_pkg;

    localparam int width        = 16;
    localparam int num_inputs   = 4;
    localparam int total_inputs = 2 * num_inputs;
    localparam int idx_w        = $clog2(total_inputs + 1);

    typedef logic [width-1:0]                  word_t;
    typedef logic [idx_w-1:0]                  idx_t;
    typedef logic [idx_w:0]                    cnt_t;
    typedef logic [total_inputs:0][width-1:0]  rf_array_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        CAPTURE = 3'd2,
        STREAM  = 3'd3,
        DONE    = 3'd4
    } rf_rd_state_t;

    // Number of words actually sent: the request trimmed so the window never
    // runs past the last regfile entry; an out-of-range start sends nothing.
    function automatic cnt_t clamp_count(input idx_t first_idx, input cnt_t num_words);
        cnt_t avail;
        cnt_t result;
        if (cnt_t'(first_idx) > cnt_t'(total_inputs)) begin
            avail = {(idx_w+1){1'b0}};
        end else begin
            avail = cnt_t'(total_inputs + 1) - cnt_t'(first_idx);
        end
        if (num_words < avail) begin
            result = num_words;
        end else begin
            result = avail;
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_reader_if.sv
// Request, regfile read and output stream signals of the regfile reader.
interface regfile_reader_if;
    import regfile_pkg::*;

    logic      start;
    idx_t      first_idx;
    cnt_t      num_words;
    logic      ren;
    rf_array_t r_data;
    word_t     out_data;
    logic      out_valid;
    logic      out_ready;
    logic      out_last;
    logic      busy;
    logic      done;

    // The reader itself.
    modport master (
        input  start, first_idx, num_words, r_data, out_ready,
        output ren, out_data, out_valid, out_last, busy, done
    );

    // The requester / regfile / downstream side.
    modport slave (
        output start, first_idx, num_words, r_data, out_ready,
        input  ren, out_data, out_valid, out_last, busy, done
    );

endinterface

// File: rtl/regfile_reader_snapshot_buf.sv
// Shadow copy of the regfile taken in one cycle, read back word by word.
module rf_snapshot_buf
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      cap_en,
    input  rf_array_t cap_data,
    input  idx_t      rd_addr,
    output word_t     rd_data
);

    rf_array_t shadow_r;

    // Capture the whole regfile when enabled; hold it otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= {((total_inputs + 1) * width){1'b0}};
        end else if (cap_en) begin
            shadow_r <= cap_data;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Read mux; addresses past the last entry return zero.
    always_comb begin
        rd_data = {width{1'b0}};
        if (rd_addr <= idx_t'(total_inputs)) begin
            rd_data = shadow_r[rd_addr];
        end else begin
            rd_data = {width{1'b0}};
        end
    end

endmodule

// File: rtl/regfile_reader.sv
// Drains a window of regfile entries over a valid/ready stream after a start
// request: one read-enable cycle, one capture cycle, then one word per beat.
module regfile_reader
    import regfile_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    regfile_reader_if.master bus
);

    rf_rd_state_t state_r;
    idx_t         first_idx_r;
    cnt_t         count_r;
    idx_t         rd_ptr_r;
    cnt_t         remaining_r;
    logic         ren_r;
    logic         out_valid_r;
    logic         out_last_r;
    word_t        out_data_r;
    logic         busy_r;
    logic         done_r;

    cnt_t         start_count_s;
    idx_t         next_addr_s;
    word_t        shadow_word_s;
    logic         accept_s;
    logic         cap_en_s;

    assign start_count_s = clamp_count(bus.first_idx, bus.num_words);
    assign next_addr_s   = rd_ptr_r + idx_t'(1'b1);
    assign accept_s      = out_valid_r & bus.out_ready;
    assign cap_en_s      = (state_r == CAPTURE);

    // The output register holds the word at rd_ptr, so the buffer is read one
    // entry ahead to have the following word ready on acceptance.
    rf_snapshot_buf u_snapshot (
        .clk      (clk),
        .rst_n    (reset),
        .cap_en   (cap_en_s),
        .cap_data (bus.r_data),
        .rd_addr  (next_addr_s),
        .rd_data  (shadow_word_s)
    );

    // Drain sequencer with all handshake outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            first_idx_r <= {idx_w{1'b0}};
            count_r     <= {(idx_w+1){1'b0}};
            rd_ptr_r    <= {idx_w{1'b0}};
            remaining_r <= {(idx_w+1){1'b0}};
            ren_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= {width{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ren_r       <= 1'b0;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    if (bus.start) begin
                        first_idx_r <= bus.first_idx;
                        count_r     <= start_count_s;
                        if (start_count_s == {(idx_w+1){1'b0}}) begin
                            // Nothing to send: skip the regfile read entirely.
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= REQ;
                            ren_r   <= 1'b1;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    ren_r   <= 1'b0;
                    state_r <= CAPTURE;
                end
                CAPTURE: begin
                    // r_data is valid now; the first word bypasses the shadow
                    // buffer, which loads in this same cycle.
                    rd_ptr_r    <= first_idx_r;
                    remaining_r <= count_r;
                    out_data_r  <= bus.r_data[first_idx_r];
                    out_valid_r <= 1'b1;
                    out_last_r  <= (count_r == cnt_t'(1'b1));
                    state_r     <= STREAM;
                end
                STREAM: begin
                    if (accept_s) begin
                        if (remaining_r == cnt_t'(1'b1)) begin
                            remaining_r <= {(idx_w+1){1'b0}};
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            rd_ptr_r    <= next_addr_s;
                            remaining_r <= remaining_r - cnt_t'(1'b1);
                            out_data_r  <= shadow_word_s;
                            out_last_r  <= (remaining_r == cnt_t'(2'd2));
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    ren_r       <= 1'b0;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.ren       = ren_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = out_last_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_regfile_reader.sv
// Directed bench for regfile_reader: one task per scenario, hand-computed words.
module tb_regfile_reader;
    import regfile_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    rf_array_t rf;
    int        tests_run = 0;
    int        tests_failed = 0;
    word_t     init_words [0:8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                                    16'h6666, 16'h7777, 16'h8888, 16'h9999, 16'hBBBB};

    regfile_reader_if bus ();
    assign bus.r_data = rf;

    regfile_reader dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rf();
        for (int i = 0; i <= total_inputs; i++) rf[i] = init_words[i];
    endtask

    // Pulse start for one edge; returns sampled in the cycle after start.
    task automatic start_drain(input idx_t fi, input cnt_t nw);
        bus.first_idx = fi;
        bus.num_words = nw;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b1; bus.out_ready = 1'b1; bus.first_idx = 4'd0; bus.num_words = 5'd9;
        repeat (3) tick();
        tests_run++; if (bus.ren !== 1'b0) begin tests_failed++; $display("FAIL reset_ren: got %b expected 0", bus.ren); end
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        tests_run++; if (bus.out_last !== 1'b0) begin tests_failed++; $display("FAIL reset_last: got %b expected 0", bus.out_last); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        tests_run++; if (bus.out_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_data: got %h expected 0000", bus.out_data); end
        bus.start = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_full_drain();
        bus.out_ready = 1'b1;
        start_drain(4'd0, 5'd9);
        tests_run++; if (bus.ren !== 1'b1) begin tests_failed++; $display("FAIL full_ren_t1: got %b expected 1", bus.ren); end
        tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL full_busy_t1: got %b expected 1", bus.busy); end
        tick();
        tests_run++; if (bus.ren !== 1'b0) begin tests_failed++; $display("FAIL full_ren_t2: got %b expected 0", bus.ren); end
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL full_valid_t2: got %b expected 0", bus.out_valid); end
        tick();
        for (int i = 0; i < 9; i++) begin
            tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL full_valid beat %0d: got %b expected 1", i, bus.out_valid); end
            tests_run++; if (bus.out_data !== init_words[i]) begin tests_failed++; $display("FAIL full_data beat %0d: got %h expected %h", i, bus.out_data, init_words[i]); end
            tests_run++; if (bus.out_last !== (i == 8)) begin tests_failed++; $display("FAIL full_last beat %0d: got %b expected %b", i, bus.out_last, (i == 8)); end
            tick();
        end
        tests_run++; if (bus.done !== 1'b1) begin tests_failed++; $display("FAIL full_done_t12: got %b expected 1", bus.done); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL full_busy_t12: got %b expected 0", bus.busy); end
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL full_valid_t12: got %b expected 0", bus.out_valid); end
        tick();
        tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL full_done_t13: got %b expected 0", bus.done); end
    endtask

    task automatic test_backpressure();
        logic  pat [0:5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        word_t exp_w [0:2] = '{16'h6666, 16'h7777, 16'h8888};
        int    acc = 0;
        logic  held = 1'b0;
        word_t prev_data = 16'h0000;
        logic  prev_last = 1'b0;
        bus.out_ready = 1'b0;
        start_drain(4'd4, 5'd3);
        for (int i = 0; i < 8 && bus.out_valid !== 1'b1; i++) tick();
        tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_timeout: out_valid %b expected 1", bus.out_valid); end
        for (int k = 0; k < 6; k++) begin
            bus.out_ready = pat[k];
            if (held) begin
                tests_run++; if (bus.out_data !== prev_data || bus.out_valid !== 1'b1 || bus.out_last !== prev_last)
                    begin tests_failed++; $display("FAIL bp_hold cycle %0d: got %h/%b/%b expected %h/1/%b", k, bus.out_data, bus.out_valid, bus.out_last, prev_data, prev_last); end
            end
            if (bus.out_valid === 1'b1 && pat[k] && acc < 3) begin
                tests_run++; if (bus.out_data !== exp_w[acc]) begin tests_failed++; $display("FAIL bp_data beat %0d: got %h expected %h", acc, bus.out_data, exp_w[acc]); end
                tests_run++; if (bus.out_last !== (acc == 2)) begin tests_failed++; $display("FAIL bp_last beat %0d: got %b expected %b", acc, bus.out_last, (acc == 2)); end
                acc++;
            end
            held = (bus.out_valid === 1'b1) && !pat[k];
            prev_data = bus.out_data;
            prev_last = bus.out_last;
            tick();
        end
        tests_run++; if (acc !== 3) begin tests_failed++; $display("FAIL bp_count: got %0d expected 3", acc); end
        tests_run++; if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_done: got done %b valid %b expected 1/0", bus.done, bus.out_valid); end
        tick();
    endtask

    task automatic test_clamp_zero();
        int   n = 0;
        logic seen;
        bus.out_ready = 1'b1;
        start_drain(4'd7, 5'd5);
        for (int i = 0; i < 8 && bus.out_valid !== 1'b1; i++) tick();
        while (bus.out_valid === 1'b1 && n < 6) begin
            tests_run++; if (bus.out_data !== init_words[7 + (n % 2)]) begin tests_failed++; $display("FAIL clamp_data beat %0d: got %h expected %h", n, bus.out_data, init_words[7 + (n % 2)]); end
            tests_run++; if (bus.out_last !== (n == 1)) begin tests_failed++; $display("FAIL clamp_last beat %0d: got %b expected %b", n, bus.out_last, (n == 1)); end
            n++;
            tick();
        end
        tests_run++; if (n !== 2) begin tests_failed++; $display("FAIL clamp_count: got %0d expected 2", n); end
        tests_run++; if (bus.done !== 1'b1) begin tests_failed++; $display("FAIL clamp_done: got %b expected 1", bus.done); end
        tick();
        for (int c = 0; c < 2; c++) begin
            if (c == 0) start_drain(4'd0, 5'd0);
            else start_drain(4'd10, 5'd3);
            tests_run++; if (bus.done !== 1'b1) begin tests_failed++; $display("FAIL zero_done case %0d: got %b expected 1", c, bus.done); end
            tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL zero_busy case %0d: got %b expected 0", c, bus.busy); end
            seen = 1'b0;
            for (int i = 0; i < 5; i++) begin
                if (bus.ren !== 1'b0 || bus.out_valid !== 1'b0) seen = 1'b1;
                tick();
            end
            tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL zero_quiet case %0d: got ren/valid activity %b expected 0", c, seen); end
        end
    endtask

    task automatic test_snapshot();
        bus.out_ready = 1'b0;
        start_drain(4'd0, 5'd2);
        for (int i = 0; i < 8 && bus.out_valid !== 1'b1; i++) tick();
        rf[0] = 16'hCCCC;
        rf[1] = 16'hDDDD;
        tick();
        tests_run++; if (bus.out_data !== 16'h1111) begin tests_failed++; $display("FAIL snap_word0: got %h expected 1111", bus.out_data); end
        bus.out_ready = 1'b1;
        tick();
        tests_run++; if (bus.out_data !== 16'h2222 || bus.out_last !== 1'b1) begin tests_failed++; $display("FAIL snap_word1: got %h last %b expected 2222 last 1", bus.out_data, bus.out_last); end
        tick();
        tick();
        start_drain(4'd0, 5'd1);
        for (int i = 0; i < 8 && bus.out_valid !== 1'b1; i++) tick();
        tests_run++; if (bus.out_data !== 16'hCCCC || bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL snap_new: got %h valid %b expected CCCC valid 1", bus.out_data, bus.out_valid); end
        tick();
        tick();
        load_rf();
    endtask

    task automatic test_busy_start();
        int   beats = 0;
        logic busy_gap = 1'b0;
        logic done_seen = 1'b0;
        logic extra = 1'b0;
        bus.out_ready = 1'b1;
        start_drain(4'd1, 5'd3);
        for (int i = 0; i < 20; i++) begin
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin done_seen = 1'b1; break; end
            if (bus.busy !== 1'b1) busy_gap = 1'b1;
            if (bus.out_valid === 1'b1) begin
                tests_run++; if (bus.out_data !== init_words[1 + beats]) begin tests_failed++; $display("FAIL busy_data beat %0d: got %h expected %h", beats, bus.out_data, init_words[1 + beats]); end
                if (beats == 0) begin bus.first_idx = 4'd0; bus.num_words = 5'd9; bus.start = 1'b1; end
                beats++;
            end
            tick();
        end
        bus.start = 1'b0;
        tests_run++; if (beats !== 3) begin tests_failed++; $display("FAIL busy_count: got %0d expected 3", beats); end
        tests_run++; if (busy_gap !== 1'b0) begin tests_failed++; $display("FAIL busy_contig: got gap %b expected 0", busy_gap); end
        tests_run++; if (done_seen !== 1'b1 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL busy_done: got done %b busy %b expected 1/0", done_seen, bus.busy); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.ren !== 1'b0 || bus.out_valid !== 1'b0) extra = 1'b1;
        end
        tests_run++; if (extra !== 1'b0) begin tests_failed++; $display("FAIL busy_noqueue: got activity %b expected 0", extra); end
    endtask

    task automatic test_reset_mid();
        logic bad = 1'b0;
        bus.out_ready = 1'b1;
        start_drain(4'd2, 5'd5);
        for (int i = 0; i < 8 && bus.out_valid !== 1'b1; i++) tick();
        tick();
        tick();
        tests_run++; if (bus.out_data !== 16'h6666) begin tests_failed++; $display("FAIL mid_pre: got %h expected 6666", bus.out_data); end
        #1 reset = 1'b0;
        #1;
        tests_run++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_last !== 1'b0)
            begin tests_failed++; $display("FAIL mid_reset: got valid %b busy %b done %b last %b expected 0/0/0/0", bus.out_valid, bus.busy, bus.done, bus.out_last); end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) bad = 1'b1;
            tick();
        end
        tests_run++; if (bad !== 1'b0) begin tests_failed++; $display("FAIL mid_quiet: got activity %b expected 0", bad); end
        start_drain(4'd2, 5'd2);
        for (int i = 0; i < 8 && bus.out_valid !== 1'b1; i++) tick();
        tests_run++; if (bus.out_data !== 16'h3333 || bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_restart0: got %h valid %b expected 3333 valid 1", bus.out_data, bus.out_valid); end
        tick();
        tests_run++; if (bus.out_data !== 16'h4444 || bus.out_last !== 1'b1) begin tests_failed++; $display("FAIL mid_restart1: got %h last %b expected 4444 last 1", bus.out_data, bus.out_last); end
        tick();
        tests_run++; if (bus.done !== 1'b1) begin tests_failed++; $display("FAIL mid_restart_done: got %b expected 1", bus.done); end
        tick();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.first_idx = 4'd0;
        bus.num_words = 5'd0;
        bus.out_ready = 1'b0;
        load_rf();
        test_reset();
        test_full_drain();
        test_backpressure();
        test_clamp_zero();
        test_snapshot();
        test_busy_start();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
